// File: rtl/csi2_packet_parser.sv
// CSI-2 byte-stream parser: header fields, payload bytes and CRC-16 check. Optional header ECC check with CSI2_ECC_CHECK_EN.
// Latency: one cycle from each qualified input byte to its registered response.
// Backpressure: none; one byte per rx_enable, no buffering.
`timescale 1ns/1ps
module csi2_packet_parser #(
    parameter logic [15:0] MAX_WORD_COUNT = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_enable,
    output logic        phy_reset,
    output logic        packet_start,
    output logic        header_valid,
    output logic [7:0]  data_id,
    output logic [15:0] word_count,
    output logic [7:0]  payload,
    output logic        payload_valid,
    output logic        packet_end,
    output logic        crc_error,
    output logic        ecc_error,
    output logic        length_error
);

    typedef enum logic [2:0] {
        IDLE, HDR1, HDR2, HDR3, PAYLOAD, CRC_LO, CRC_HI
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  hdr_dt, hdr_dt_nxt;
    logic [15:0] hdr_wc, hdr_wc_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] crc, crc_nxt;
    logic [7:0]  crc_lo, crc_lo_nxt;

    logic        phy_reset_nxt, packet_start_nxt, header_valid_nxt, payload_valid_nxt;
    logic        packet_end_nxt, crc_error_nxt, ecc_error_nxt, length_error_nxt;
    logic [7:0]  data_id_nxt, payload_nxt;
    logic [15:0] word_count_nxt;

    logic is_long, len_bad, ecc_bad, abort;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    assign is_long = (hdr_dt[5:0] >= 6'h10);
    assign len_bad = is_long && (hdr_wc > MAX_WORD_COUNT);

`ifdef CSI2_ECC_CHECK_EN
    // Parity masks over {byte2, byte1, byte0}; bit 0 is byte 0 bit 0.
    localparam logic [23:0] ECC_MASK [6] = '{
        24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00
    };
    logic [23:0] hdr_bits;
    logic [5:0]  syndrome;
    assign hdr_bits = {hdr_wc, hdr_dt};
    always_comb begin
        syndrome = '0;
        for (int k = 0; k < 6; k++) begin
            syndrome[k] = ^(hdr_bits & ECC_MASK[k]) ^ rx_data[k];
        end
    end
    assign ecc_bad = (syndrome != 6'd0) || (rx_data[7:6] != 2'd0);
`else
    assign ecc_bad = 1'b0;
`endif

    assign abort = ecc_bad || len_bad;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (rx_enable) begin
            case (state)
                IDLE:    state_nxt = HDR1;
                HDR1:    state_nxt = HDR2;
                HDR2:    state_nxt = HDR3;
                HDR3: begin
                    if (abort || !is_long)  state_nxt = IDLE;
                    else if (hdr_wc == 16'd0) state_nxt = CRC_LO;
                    else                      state_nxt = PAYLOAD;
                end
                PAYLOAD: if (cnt == 16'd1) state_nxt = CRC_LO;
                CRC_LO:  state_nxt = CRC_HI;
                CRC_HI:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        phy_reset_nxt     = 1'b0;
        packet_start_nxt  = 1'b0;
        header_valid_nxt  = 1'b0;
        payload_valid_nxt = 1'b0;
        packet_end_nxt    = 1'b0;
        crc_error_nxt     = crc_error;
        ecc_error_nxt     = ecc_error;
        length_error_nxt  = length_error;
        data_id_nxt       = data_id;
        word_count_nxt    = word_count;
        payload_nxt       = payload;
        hdr_dt_nxt        = hdr_dt;
        hdr_wc_nxt        = hdr_wc;
        cnt_nxt           = cnt;
        crc_nxt           = crc;
        crc_lo_nxt        = crc_lo;
        if (rx_enable) begin
            case (state)
                IDLE: begin
                    hdr_dt_nxt       = rx_data;
                    packet_start_nxt = 1'b1;
                    crc_error_nxt    = 1'b0;
                    ecc_error_nxt    = 1'b0;
                    length_error_nxt = 1'b0;
                end
                HDR1: hdr_wc_nxt[7:0]  = rx_data;
                HDR2: hdr_wc_nxt[15:8] = rx_data;
                HDR3: begin
                    header_valid_nxt = 1'b1;
                    data_id_nxt      = hdr_dt;
                    word_count_nxt   = hdr_wc;
                    ecc_error_nxt    = ecc_bad;
                    length_error_nxt = len_bad;
                    if (abort || !is_long) begin
                        packet_end_nxt = 1'b1;
                        phy_reset_nxt  = 1'b1;
                    end else begin
                        crc_nxt = 16'hFFFF;
                        cnt_nxt = hdr_wc;
                    end
                end
                PAYLOAD: begin
                    payload_nxt       = rx_data;
                    payload_valid_nxt = 1'b1;
                    crc_nxt           = crc_byte(crc, rx_data);
                    cnt_nxt           = cnt - 16'd1;
                end
                CRC_LO: crc_lo_nxt = rx_data;
                CRC_HI: begin
                    crc_error_nxt  = ({rx_data, crc_lo} != crc);
                    packet_end_nxt = 1'b1;
                    phy_reset_nxt  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phy_reset     <= 1'b0;
            packet_start  <= 1'b0;
            header_valid  <= 1'b0;
            payload_valid <= 1'b0;
            packet_end    <= 1'b0;
            crc_error     <= 1'b0;
            ecc_error     <= 1'b0;
            length_error  <= 1'b0;
            data_id       <= '0;
            word_count    <= '0;
            payload       <= '0;
            hdr_dt        <= '0;
            hdr_wc        <= '0;
            cnt           <= '0;
            crc           <= '0;
            crc_lo        <= '0;
        end else begin
            phy_reset     <= phy_reset_nxt;
            packet_start  <= packet_start_nxt;
            header_valid  <= header_valid_nxt;
            payload_valid <= payload_valid_nxt;
            packet_end    <= packet_end_nxt;
            crc_error     <= crc_error_nxt;
            ecc_error     <= ecc_error_nxt;
            length_error  <= length_error_nxt;
            data_id       <= data_id_nxt;
            word_count    <= word_count_nxt;
            payload       <= payload_nxt;
            hdr_dt        <= hdr_dt_nxt;
            hdr_wc        <= hdr_wc_nxt;
            cnt           <= cnt_nxt;
            crc           <= crc_nxt;
            crc_lo        <= crc_lo_nxt;
        end
    end

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Bench for csi2_packet_parser: packet-level reference model, directed and randomized packets.
`timescale 1ns/1ps
module tb_csi2_packet_parser;

    typedef struct packed {
        logic        ps, hv, pv, pe, pr;
        logic [7:0]  did;
        logic [15:0] wc;
        logic [7:0]  pl;
        logic        ce, ee, le;
    } obs_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_enable = 1'b0;

    logic m_pr, m_ps, m_hv, m_pv, m_pe, m_ce, m_ee, m_le;
    logic [7:0] m_did, m_pl;
    logic [15:0] m_wc;
    logic l_pr, l_ps, l_hv, l_pv, l_pe, l_ce, l_ee, l_le;
    logic [7:0] l_did, l_pl;
    logic [15:0] l_wc;
    obs_t obs0, obs1;

    int checks = 0;
    int errors = 0;
    bit sel = 1'b0;
    logic [7:0] pl_q [$];

    // Syndrome column per header data bit D0..D23.
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    csi2_packet_parser dut (
        .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_enable(rx_enable),
        .phy_reset(m_pr), .packet_start(m_ps), .header_valid(m_hv), .data_id(m_did),
        .word_count(m_wc), .payload(m_pl), .payload_valid(m_pv), .packet_end(m_pe),
        .crc_error(m_ce), .ecc_error(m_ee), .length_error(m_le)
    );

    csi2_packet_parser #(.MAX_WORD_COUNT(16'd16)) dut_lim (
        .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_enable(rx_enable),
        .phy_reset(l_pr), .packet_start(l_ps), .header_valid(l_hv), .data_id(l_did),
        .word_count(l_wc), .payload(l_pl), .payload_valid(l_pv), .packet_end(l_pe),
        .crc_error(l_ce), .ecc_error(l_ee), .length_error(l_le)
    );

    assign obs0 = {m_ps, m_hv, m_pv, m_pe, m_pr, m_did, m_wc, m_pl, m_ce, m_ee, m_le};
    assign obs1 = {l_ps, l_hv, l_pv, l_pe, l_pr, l_did, l_wc, l_pl, l_ce, l_ee, l_le};

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] calc_ecc(input logic [7:0] dt, input logic [15:0] wc);
        logic [23:0] d;
        logic [5:0]  e;
        d = {wc, dt};
        e = '0;
        for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_COL[i];
        return {2'b00, e};
    endfunction

    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        foreach (pl_q[k]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ pl_q[k][j];
                c  = c >> 1;
                if (fb) c ^= 16'h8408;
            end
        end
        return c;
    endfunction

    task automatic step(input logic [7:0] b, input bit b2b, output obs_t o);
        @(negedge clock);
        if (!b2b) begin
            rx_enable = 1'b0;
            repeat (3) @(negedge clock);
        end
        rx_data   = b;
        rx_enable = 1'b1;
        @(posedge clock);
        #1;
        o = sel ? obs1 : obs0;
    endtask

    task automatic idle(input int n);
        @(negedge clock);
        rx_enable = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        rx_enable = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Drives one packet (payload taken from pl_q) and checks every byte's response.
    task automatic run_packet(input string name, input logic [7:0] dt, input logic [15:0] wc,
                              input logic [7:0] ecc_b, input logic [15:0] footer,
                              input bit b2b, input logic [15:0] maxwc);
        logic [7:0] hdr [4];
        logic [7:0] ftr [2];
        obs_t o;
        logic [4:0] got, want;
        bit is_long, ecc_bad, len_bad, ends_hdr, crc_bad;
        is_long = (dt[5:0] >= 6'h10);
`ifdef CSI2_ECC_CHECK_EN
        ecc_bad = (ecc_b != calc_ecc(dt, wc));
`else
        ecc_bad = 1'b0;
`endif
        len_bad  = is_long && (wc > maxwc);
        ends_hdr = ecc_bad || len_bad || !is_long;
        crc_bad  = (footer != model_crc());
        hdr[0] = dt; hdr[1] = wc[7:0]; hdr[2] = wc[15:8]; hdr[3] = ecc_b;
        for (int i = 0; i < 4; i++) begin
            step(hdr[i], b2b, o);
            got = {o.ps, o.hv, o.pv, o.pe, o.pr};
            if (i == 0)      want = 5'b10000;
            else if (i < 3)  want = 5'b00000;
            else             want = {2'b01, 1'b0, ends_hdr, ends_hdr};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s hdr%0d pulses: got %b want %b", name, i, got, want);
            end
            if (i == 0) begin
                checks++;
                if ({o.ce, o.ee, o.le} !== 3'b000) begin
                    errors++;
                    $display("FAIL %s flags_clear: got %b want 000", name, {o.ce, o.ee, o.le});
                end
            end
            if (i == 3) begin
                checks++;
                if (o.did !== dt || o.wc !== wc) begin
                    errors++;
                    $display("FAIL %s header_fields: got %h/%h want %h/%h", name, o.did, o.wc, dt, wc);
                end
                checks++;
                if ({o.ce, o.ee, o.le} !== {1'b0, ecc_bad, len_bad}) begin
                    errors++;
                    $display("FAIL %s hdr_errors: got %b want %b", name, {o.ce, o.ee, o.le},
                             {1'b0, ecc_bad, len_bad});
                end
            end
        end
        if (!ends_hdr) begin
            foreach (pl_q[k]) begin
                step(pl_q[k], b2b, o);
                checks++;
                if ({o.ps, o.hv, o.pv, o.pe, o.pr} !== 5'b00100 || o.pl !== pl_q[k]) begin
                    errors++;
                    $display("FAIL %s payload%0d: got %b/%h want 00100/%h", name, k,
                             {o.ps, o.hv, o.pv, o.pe, o.pr}, o.pl, pl_q[k]);
                end
            end
            ftr[0] = footer[7:0]; ftr[1] = footer[15:8];
            for (int i = 0; i < 2; i++) begin
                step(ftr[i], b2b, o);
                got  = {o.ps, o.hv, o.pv, o.pe, o.pr};
                want = (i == 1) ? 5'b00011 : 5'b00000;
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s footer%0d pulses: got %b want %b", name, i, got, want);
                end
            end
            checks++;
            if (o.ce !== crc_bad) begin
                errors++;
                $display("FAIL %s crc_error: got %b want %b", name, o.ce, crc_bad);
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (obs0 !== '0 || obs1 !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h/%h want 0", obs0, obs1);
        end
        do_reset();
        idle(4);
        checks++;
        if (obs0 !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: got %h want 0", obs0);
        end
    endtask

    task automatic test_short();
        sel = 1'b0;
        pl_q.delete();
        run_packet("short_zero", 8'h00, 16'h0000, 8'h00, 16'h0000, 1'b0, 16'hFFFF);
        pl_q.delete();
        run_packet("short_data", 8'h4F, 16'hBEEF, calc_ecc(8'h4F, 16'hBEEF), 16'h0000, 1'b0, 16'hFFFF);
    endtask

    task automatic test_crc();
        logic [7:0] v [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                               8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                               8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
        sel = 1'b0;
        pl_q.delete();
        foreach (v[i]) pl_q.push_back(v[i]);
        run_packet("crc_good", 8'h2A, 16'h0018, calc_ecc(8'h2A, 16'h0018), 16'h00F0, 1'b0, 16'hFFFF);
        checks++;
        if (m_ce !== 1'b0) begin
            errors++;
            $display("FAIL crc_good_vector: got %b want 0", m_ce);
        end
        run_packet("crc_bad", 8'h2A, 16'h0018, calc_ecc(8'h2A, 16'h0018), 16'h00F1, 1'b0, 16'hFFFF);
        checks++;
        if (m_ce !== 1'b1) begin
            errors++;
            $display("FAIL crc_bad_vector: got %b want 1", m_ce);
        end
    endtask

    task automatic test_ecc();
        obs_t o;
        sel = 1'b0;
        pl_q.delete();
`ifdef CSI2_ECC_CHECK_EN
        run_packet("ecc_flip", 8'h01, 16'h0000, 8'h00, 16'h0000, 1'b0, 16'hFFFF);
        checks++;
        if (m_ee !== 1'b1) begin
            errors++;
            $display("FAIL ecc_flip_flag: got %b want 1", m_ee);
        end
        for (int i = 0; i < 3; i++) begin
            step(8'h5A, 1'b0, o);
            checks++;
            if (o.pv !== 1'b0) begin
                errors++;
                $display("FAIL ecc_no_payload%0d: got %b want 0", i, o.pv);
            end
        end
        do_reset();
        run_packet("ecc_high_bits", 8'h2A, 16'h0004, calc_ecc(8'h2A, 16'h0004) | 8'h40,
                   16'h0000, 1'b0, 16'hFFFF);
`else
        run_packet("ecc_ignored", 8'h2A, 16'h0000, 8'hA5, 16'hFFFF, 1'b0, 16'hFFFF);
        checks++;
        if (m_ee !== 1'b0) begin
            errors++;
            $display("FAIL ecc_ignored_flag: got %b want 0", m_ee);
        end
`endif
    endtask

    task automatic test_length();
        do_reset();
        sel = 1'b1;
        pl_q.delete();
        run_packet("len_17", 8'h2A, 16'd17, calc_ecc(8'h2A, 16'd17), 16'h0000, 1'b0, 16'd16);
        checks++;
        if (l_le !== 1'b1) begin
            errors++;
            $display("FAIL len_17_flag: got %b want 1", l_le);
        end
        for (int i = 0; i < 16; i++) pl_q.push_back(8'($urandom));
        run_packet("len_16", 8'h2B, 16'd16, calc_ecc(8'h2B, 16'd16), model_crc(), 1'b0, 16'd16);
        pl_q.delete();
        run_packet("len_short", 8'h01, 16'hFFFF, calc_ecc(8'h01, 16'hFFFF), 16'h0000, 1'b0, 16'd16);
        do_reset();
        sel = 1'b0;
        run_packet("empty_long", 8'h2A, 16'h0000, calc_ecc(8'h2A, 16'h0000), 16'hFFFF, 1'b0, 16'hFFFF);
        checks++;
        if (m_ce !== 1'b0) begin
            errors++;
            $display("FAIL empty_crc: got %b want 0", m_ce);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic [7:0] hdr [4];
        bit seen_end;
        do_reset();
        sel = 1'b0;
        hdr[0] = 8'h2A; hdr[1] = 8'h0A; hdr[2] = 8'h00; hdr[3] = calc_ecc(8'h2A, 16'h000A);
        for (int i = 0; i < 4; i++) step(hdr[i], 1'b0, o);
        for (int i = 0; i < 5; i++) step(8'h30 + 8'(i), 1'b0, o);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs0 !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h want 0", obs0);
        end
        repeat (3) @(negedge clock);
        rx_enable = 1'b0;
        reset_n   = 1'b1;
        seen_end  = 1'b0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (m_pe) seen_end = 1'b1;
        end
        checks++;
        if (seen_end !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_end: got %b want 0", seen_end);
        end
        pl_q.delete();
        run_packet("after_reset", 8'h00, 16'h1234, calc_ecc(8'h00, 16'h1234), 16'h0000, 1'b0, 16'hFFFF);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  dt, ecc_b;
        logic [15:0] wc, footer, flip;
        bit b2b;
        do_reset();
        sel = 1'b0;
        for (int n = 0; n < 40; n++) begin
            pl_q.delete();
            dt  = 8'($urandom);
            b2b = (n < 8) ? 1'b1 : 1'($urandom);
            if (dt[5:0] < 6'h10) begin
                wc = 16'($urandom);
            end else begin
                wc = 16'($urandom_range(0, 12));
                for (int k = 0; k < int'(wc); k++) pl_q.push_back(8'($urandom));
            end
            ecc_b = calc_ecc(dt, wc);
`ifdef CSI2_ECC_CHECK_EN
            if ($urandom_range(0, 7) == 0) ecc_b = ecc_b ^ (8'h01 << $urandom_range(0, 7));
`endif
            footer = model_crc();
            if ($urandom_range(0, 3) == 0) begin
                flip   = 16'($urandom_range(1, 65535));
                footer = footer ^ flip;
            end
            run_packet($sformatf("rand%0d", n), dt, wc, ecc_b, footer, b2b, 16'hFFFF);
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_short();
        test_crc();
        test_ecc();
        test_length();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csi2_packet_parser.md
# csi2_packet_parser

Byte-level CSI-2 low-level protocol parser that sits directly downstream of the single-lane D-PHY HS receiver. It consumes the receiver's `data`/`enable` byte stream and splits it into packet header fields and payload bytes. It checks the payload CRC-16 and, optionally, the header ECC. At the end of every packet it drives the receiver's synchronous reset, because the PHY cannot detect LP stop on its own.

## Interface
Parameters:
- `MAX_WORD_COUNT`, default 16'hFFFF: the largest long-packet word count accepted. Headers with a larger count abort the packet.

Ports:
- `clock`  input  1: the receiver's `clock_p`; every register is on its rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `rx_data`  input  8: byte from the receiver (`data`).
- `rx_enable`  input  1: byte qualifier from the receiver (`enable`). Only cycles with this bit high carry a byte.
- `phy_reset`  output  1: one-cycle pulse wired to the receiver's `reset`.
- `packet_start`  output  1: pulse on capture of the first header byte.
- `header_valid`  output  1: pulse when `data_id`, `word_count` and `ecc_error` are valid.
- `data_id`  output  8: bits 7:6 are the virtual channel, bits 5:0 are the data type. Held until the next header.
- `word_count`  output  16: the header word count, or the data field for short packets. Held until the next header.
- `payload`  output  8: payload byte.
- `payload_valid`  output  1: qualifies `payload`.
- `packet_end`  output  1: pulse when the packet completes or aborts.
- `crc_error`  output  1: valid with `packet_end`; held until the next `packet_start`.
- `ecc_error`  output  1: valid with `header_valid`; held until the next `packet_start`.
- `length_error`  output  1: valid with `header_valid`; held until the next `packet_start`.

## Operation
- The decision logic is a state machine with states IDLE, HDR1, HDR2, HDR3, PAYLOAD, CRC_LO and CRC_HI.
- The state machine advances only on cycles where `rx_enable` is 1. Cycles where it is 0 hold state.
- **IDLE.** A byte is stored as header byte 0, `packet_start` pulses, all error flags clear, and the state goes to HDR1.
- **HDR1, HDR2.** These store the word count, LSB first (HDR1 takes bits 7:0, HDR2 takes bits 15:8).
- **HDR3.** This stores the ECC byte and evaluates the header:
  - If the ECC check fails (configuration-dependent) or `word_count > MAX_WORD_COUNT`, the packet aborts:
    - `header_valid`, `packet_end` and `phy_reset` pulse together, with the matching error flag set.
    - The state returns to IDLE and no payload is emitted.
    - The `MAX_WORD_COUNT` limit applies to long packets only.
  - If the data type is below 6'h10, the packet is short:
    - `header_valid`, `packet_end` and `phy_reset` pulse together.
    - `crc_error` stays 0 and the state goes to IDLE.
  - For a long packet, `header_valid` pulses, the CRC register is set to 16'hFFFF and the byte counter is loaded with `word_count`.
    - A count of 0 goes to CRC_LO; any other count goes to PAYLOAD.
- **PAYLOAD.**
  - Each byte is sent to `payload` with `payload_valid` high and is folded into the CRC.
  - The counter decrements on each byte; when it reaches 1 on a byte, the state goes to CRC_LO.
- **CRC arithmetic.**
  - Polynomial x^16+x^12+x^5+1, reflected and processed LSB first (shift-right form, constant 16'h8408).
  - Seed 16'hFFFF, no final XOR.
- **CRC_LO, CRC_HI.** These receive the footer, LSB byte first. On the CRC_HI byte:
  - `crc_error` is set to (received != computed).
  - `packet_end` and `phy_reset` pulse, and the state goes to IDLE.
- **Reset mid-packet.** Deasserting `reset_n` at any time returns the block to IDLE immediately.
  - All outputs go to 0: pulses, flags, `data_id`, `word_count` and `payload`.
  - The partial packet is discarded with no `packet_end`.

## Timing
- All outputs are registered. Every response appears on the clock edge that samples the qualifying `rx_enable` byte, so latency is one cycle from the input byte.
- `phy_reset` is high for exactly one cycle. The receiver samples it on the next edge, before its next `enable` (four cycles later), so no stale byte is accepted.
- Throughput is one byte per `rx_enable`. The block has no backpressure and no buffering.
- Back-to-back `rx_enable` on consecutive cycles must be handled correctly, even though the receiver never produces it.

## Configuration
- `CSI2_ECC_CHECK_EN` defined:
  - The 6-bit MIPI CSI-2 Hamming syndrome is computed over header bytes 0–2 and compared with ECC byte bits 5:0.
  - Any nonzero syndrome, or ECC bits 7:6 being nonzero, sets `ecc_error` and aborts the packet.
  - No single-bit correction is performed.
- `CSI2_ECC_CHECK_EN` undefined:
  - No syndrome logic is built, `ecc_error` is constant 0 and the ECC byte is ignored.

## Test plan
- **Short packet.** Bytes 00 00 00 00 with `rx_enable` every 4th cycle → `header_valid`, `packet_end` and `phy_reset` high together one cycle after the 4th byte; `data_id`=8'h00, `word_count`=16'h0000, all errors 0.
- **Long packet, CRC good.** Header 2A 18 00 with a valid ECC byte, then the 24 bytes FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01, then footer F0 00 → 24 `payload_valid` pulses in order, then `packet_end` with `crc_error`=0.
- **Long packet, CRC bad.** The same stream with footer F1 00 → `crc_error`=1 with `packet_end`, and `phy_reset` pulses.
- **ECC (with `CSI2_ECC_CHECK_EN`).** Header 01 00 00 00 (bit 0 flipped) → `ecc_error`=1, `packet_end` and `phy_reset` on the header's last byte, and no `payload_valid` for the following bytes.
- **Length limit and empty packet.** With `MAX_WORD_COUNT`=16, header WC=17 → `length_error`=1 and abort. With WC=0 and footer FF FF → no payload and `crc_error`=0.
- **Reset mid-payload.** Drop `reset_n` after payload byte 5 → all outputs are 0 asynchronously and no `packet_end`. A subsequent short packet parses correctly.
